// File: rtl/alu_issue_stage_pkg.sv
// Shared types and constants for the ALU issue slice: operand type, ALUOp
// encoding (aligned with funct3), RV32I opcode/funct7 constants and the decoded bundle.
package alu_issue_stage_pkg;

    typedef logic [31:0] data_t;
    typedef logic        bool_t;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SLL  = 3'd1,
        ALU_SLT  = 3'd2,
        ALU_SLTU = 3'd3,
        ALU_XOR  = 3'd4,
        ALU_SR   = 3'd5,
        ALU_OR   = 3'd6,
        ALU_AND  = 3'd7
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef struct packed {
        data_t      a;
        data_t      b;
        alu_op_e    op;
        bool_t      mod;
        logic [4:0] rd;
        bool_t      rd_we;
        bool_t      illegal;
    } decoded_alu_t;

    function automatic data_t i_imm(input logic [31:0] instr);
        logic signed [11:0] imm;
        imm = $signed(instr[31:20]);
        return data_t'(32'(imm));
    endfunction

    function automatic data_t u_imm(input logic [31:0] instr);
        return {instr[31:12], 12'b0};
    endfunction

    function automatic data_t shamt(input logic [31:0] instr);
        return {27'b0, instr[24:20]};
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I decoder for OP, OP-IMM, LUI and AUIPC onto the ALU
// operand interface; anything else is flagged illegal with neutral operands.
module alu_decode
    import alu_issue_stage_pkg::*;
(
    input  logic [31:0]  instr,
    input  logic [31:0]  pc,
    input  logic [31:0]  rs1_data,
    input  logic [31:0]  rs2_data,
    output decoded_alu_t dec
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       legal;
    data_t      a_raw;
    data_t      b_raw;
    alu_op_e    op_raw;
    logic       mod_raw;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    always_comb begin
        legal   = 1'b0;
        a_raw   = '0;
        b_raw   = '0;
        op_raw  = ALU_ADD;
        mod_raw = 1'b0;
        unique case (opcode)
            OPC_OP: begin
                a_raw  = rs1_data;
                b_raw  = rs2_data;
                op_raw = alu_op_e'(funct3);
                legal  = (funct7 == F7_BASE) ||
                         ((funct7 == F7_ALT) && ((funct3 == 3'd0) || (funct3 == 3'd5)));
                // SUB is folded into ADD by negating the second operand.
                if ((funct3 == 3'd0) && (funct7 == F7_ALT)) begin
                    b_raw = ~rs2_data + 32'd1;
                end
                if (funct3 == 3'd5) begin
                    mod_raw = funct7[5];
                end
            end
            OPC_OP_IMM: begin
                a_raw  = rs1_data;
                op_raw = alu_op_e'(funct3);
                if (funct3 == 3'd1) begin
                    b_raw = shamt(instr);
                    legal = (funct7 == F7_BASE);
                end else if (funct3 == 3'd5) begin
                    b_raw   = shamt(instr);
                    legal   = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    mod_raw = funct7[5];
                end else begin
                    b_raw = i_imm(instr);
                    legal = 1'b1;
                end
            end
            OPC_LUI: begin
                b_raw = u_imm(instr);
                legal = 1'b1;
            end
            OPC_AUIPC: begin
                a_raw = pc;
                b_raw = u_imm(instr);
                legal = 1'b1;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

    // Illegal encodings present neutral operands so execute never sees stale data.
    always_comb begin
        dec         = '0;
        dec.rd      = instr[11:7];
        dec.illegal = !legal;
        if (legal) begin
            dec.a     = a_raw;
            dec.b     = b_raw;
            dec.op    = op_raw;
            dec.mod   = mod_raw;
            dec.rd_we = (instr[11:7] != 5'd0);
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage: decodes one instruction per handshake into the ID/EX
// register feeding the ALU, with backpressure, flush and an issued counter.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic             flush,
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [XLEN-1:0]  ex_a,
    output logic [XLEN-1:0]  ex_b,
    output logic [2:0]       ex_op,
    output logic             ex_mod,
    output logic [4:0]       ex_rd,
    output logic             ex_rd_we,
    output logic             ex_illegal,
    output logic [CNT_W-1:0] issued_cnt
);

    decoded_alu_t     dec;
    decoded_alu_t     ex_d;
    decoded_alu_t     ex_q;
    logic             ex_valid_d;
    logic             ex_valid_q;
    logic [CNT_W-1:0] issued_cnt_d;
    logic [CNT_W-1:0] issued_cnt_q;
    logic             accept;
    logic             consume;

    alu_decode u_decode (
        .instr    (in_instr),
        .pc       (in_pc),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .dec      (dec)
    );

    assign in_ready = !ex_valid_q || ex_ready;
    // A flush kills both the held entry and whatever is handshaking this cycle.
    assign accept   = in_valid && in_ready && !flush;
    assign consume  = ex_valid_q && ex_ready && !flush;

    always_comb begin
        ex_valid_d = ex_valid_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (accept) begin
            ex_valid_d = 1'b1;
        end else if (ex_ready) begin
            ex_valid_d = 1'b0;
        end
    end

    always_comb begin
        ex_d = ex_q;
        if (accept) begin
            ex_d = dec;
        end
    end

    always_comb begin
        issued_cnt_d = issued_cnt_q + {{(CNT_W-1){1'b0}}, consume};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q   <= 1'b0;
            ex_q         <= '0;
            issued_cnt_q <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_q         <= ex_d;
            issued_cnt_q <= issued_cnt_d;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_a       = ex_q.a;
    assign ex_b       = ex_q.b;
    assign ex_op      = ex_q.op;
    assign ex_mod     = ex_q.mod;
    assign ex_rd      = ex_q.rd;
    assign ex_rd_we   = ex_q.rd_we;
    assign ex_illegal = ex_q.illegal;
    assign issued_cnt = issued_cnt_q;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/issue stage that drives the ALU operand interface: a, b, op, mod.
- Accepts one 32-bit instruction per cycle with valid/ready handshake.
- Decodes RV32I OP, OP-IMM, LUI and AUIPC into ALUOp/mod/operands and registers them into the ID/EX pipeline register.
- Sits between fetch/register-file read and the execute stage; handles backpressure, flush and illegal-instruction marking.

Parameters:
- XLEN, 32, datapath width; must match Data.
- CNT_W, 32, width of the issued-instruction counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- in_valid  in  1  instruction valid from fetch
- in_ready  out  1  stage can accept this cycle
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction PC
- rs1_data  in  XLEN  register-file read of instr[19:15], same cycle
- rs2_data  in  XLEN  register-file read of instr[24:20], same cycle
- flush  in  1  discard held and incoming instruction
- ex_valid  out  1  ID/EX register holds an instruction
- ex_ready  in  1  execute consumes this cycle
- ex_a  out  XLEN  ALU operand a
- ex_b  out  XLEN  ALU operand b
- ex_op  out  3  ALUOp
- ex_mod  out  1  arithmetic-shift modifier
- ex_rd  out  5  destination register
- ex_rd_we  out  1  write-back enable
- ex_illegal  out  1  undecodable instruction
- issued_cnt  out  CNT_W  count of instructions handed to execute

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous and active-low.
- Reset values: ex_valid=0; ex_a, ex_b, ex_op, ex_mod, ex_rd, ex_rd_we, ex_illegal all 0; issued_cnt=0.
- Handshake:
  - in_ready = !ex_valid || ex_ready (combinational).
  - Accept when in_valid && in_ready; the ID/EX register loads next edge. Latency is 1 cycle.
  - Hold when ex_valid && !ex_ready: all ex_* outputs stable, no accept.
  - Consume without new accept: ex_valid falls next edge.
- Flush is synchronous and takes priority:
  - ex_valid=0 next edge.
  - An instruction handshaked in the same cycle is discarded.
  - issued_cnt does not increment.
- issued_cnt increments on every ex_valid && ex_ready && !flush edge, and wraps at 2^CNT_W.
- ALUOp encoding equals funct3: ADD=0, SLL=1, SLT=2, SLTU=3, XOR=4, SR=5, OR=6, AND=7.
- Decode by opcode instr[6:0]:
  - 0110011 (OP):
    - a=rs1_data, op=funct3.
    - funct7 must be 0x00, or 0x20 only for funct3 0 and 5.
    - funct3=0 with funct7=0x20 (SUB): op=ADD, b=~rs2_data+1 (two's complement, wraps; 0x80000000 maps to itself).
    - Otherwise b=rs2_data.
    - mod=funct7[5] for SR, else 0.
  - 0010011 (OP-IMM):
    - a=rs1_data, op=funct3.
    - For funct3 1 or 5: b=zero-extended instr[24:20] (shamt).
      - funct3=1 requires funct7=0x00.
      - funct3=5 requires funct7 0x00 or 0x20; mod=funct7[5].
    - Otherwise b=sign-extended instr[31:20], mod=0.
  - 0110111 (LUI): a=0, b={instr[31:12],12'b0}, op=ADD.
  - 0010111 (AUIPC): a=in_pc, b={instr[31:12],12'b0}, op=ADD.
  - Any other opcode or illegal funct7: ex_illegal=1, ex_rd_we=0, op=ADD, a=b=0, mod=0.
- Write-back: ex_rd=instr[11:7]. ex_rd_we=1 only for legal instructions with rd!=0.
- Reset asserted mid-operation: all outputs return to reset values immediately; the pending instruction is lost.

Decomposition:
- Shared package (existing):
  - Data, Bool, ALUOp enum with the funct3-aligned encoding above.
  - Opcode constants OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC.
  - Funct7 constants F7_BASE=0x00, F7_ALT=0x20.
  - DecodedAlu struct {a, b, op, mod, rd, rd_we, illegal}.
- Sub-module alu_decode: purely combinational instruction+operands -> DecodedAlu.
- alu_issue_stage: ID/EX register, handshake, flush and counter.

Test Plan:
- ADDI x5,x1,-1 (0xFFF08293), rs1=10 -> next cycle ex_valid=1, a=10, b=0xFFFFFFFF, op=ADD, rd=5, rd_we=1.
- SUB x3,x1,x2 (0x402081B3), rs1=7, rs2=3 -> op=ADD, b=0xFFFFFFFD; SRAI x4,x1,4 (0x4040D213) -> op=SR, mod=1, b=4.
- AUIPC x1,0x12345 at pc=0x100 -> a=0x100, b=0x12345000, op=ADD; LUI with rd=0 -> rd_we=0.
- Hold ex_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, ex_* stable. Then ex_ready=1 -> in_ready=1, next instruction loads the following cycle, issued_cnt +1.
- flush=1 in the same cycle as an accepted instruction -> ex_valid=0 next cycle, issued_cnt unchanged. Opcode 0x7F -> ex_illegal=1, rd_we=0.
- Drop rst_n asynchronously mid-hold -> ex_valid=0 and issued_cnt=0 before the next clk edge.
